// File: rtl/ex_stage_mc_pkg.sv
// ============================================================================
//  Module   : ex_stage_mc_pkg
//  Purpose  : Shared types for the multi-cycle execute stage: ALU op codes,
//             FSM states, branch condition codes and forwarding constants.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ex_stage_mc_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_LUI    = 5'd10,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Forward-select value meaning "take the register file operand".
  localparam int FWD_RF = 0;

  function automatic logic is_mop(input alu_op_e op);
    return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_stage_mc_if.sv
// ============================================================================
//  Module   : ex_stage_mc_if
//  Purpose  : Bundle of ID->EX request, EX->LS result and control signals.
//  Ports    : master modport = ID/LS side (drives op, sees result)
//             slave  modport = execute stage
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_stage_mc_if #(
  parameter int XLEN = 64,
  parameter int NFWD = 3
);
  import ex_stage_mc_pkg::*;

  localparam int SELW = $clog2(NFWD + 1);

  logic                 in_valid_i;
  logic                 in_ready_o;
  alu_op_e              aluctr_i;
  logic [XLEN-1:0]      rs1_i;
  logic [XLEN-1:0]      rs2_i;
  logic [XLEN-1:0]      imm_i;
  logic [XLEN-1:0]      pc_i;
  logic [2:0]           fun3_i;
  logic                 src1sel_i;
  logic [1:0]           src2sel_i;
  logic [SELW-1:0]      rs1_sel_i;
  logic [SELW-1:0]      rs2_sel_i;
  logic [NFWD*XLEN-1:0] fwd_data_i;
  logic                 is_jal_i;
  logic                 is_jalr_i;
  logic                 is_brc_i;
  logic                 flush_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [XLEN-1:0]      alures_o;
  logic [XLEN-1:0]      rs2_o;
  logic [XLEN-1:0]      pc_next_o;
  logic                 is_jump_o;
  logic                 busy_o;

  modport master (
    output in_valid_i, aluctr_i, rs1_i, rs2_i, imm_i, pc_i, fun3_i,
           src1sel_i, src2sel_i, rs1_sel_i, rs2_sel_i, fwd_data_i,
           is_jal_i, is_jalr_i, is_brc_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, alures_o, rs2_o, pc_next_o,
           is_jump_o, busy_o
  );

  modport slave (
    input  in_valid_i, aluctr_i, rs1_i, rs2_i, imm_i, pc_i, fun3_i,
           src1sel_i, src2sel_i, rs1_sel_i, rs2_sel_i, fwd_data_i,
           is_jal_i, is_jalr_i, is_brc_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, alures_o, rs2_o, pc_next_o,
           is_jump_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/ex_stage_mc_mdu.sv
// ============================================================================
//  Module   : ex_mdu
//  Purpose  : Iterative multiply/divide, one bit per cycle, XLEN iterations.
//             Works on operand magnitudes and fixes signs at the end.
//  Ports    : clk, rst_n      clock, async active-low reset
//             start_i         load operands (ignored while kill_i)
//             kill_i          abandon current operation
//             op_i, a_i, b_i  M-op code and operands
//             done_o, res_o   result valid (held until next cycle), result
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mdu
  import ex_stage_mc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            kill_i,
  input  alu_op_e         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN + 1);

  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  // hi/lo: product accumulator for MUL, remainder/quotient for DIV.
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic            div_q, div_d, hsel_q, hsel_d, neg_q, neg_d, bzero_q, bzero_d;

  logic            is_div, a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0] a_abs, b_abs;
  logic [XLEN:0]   mul_sum, rem_sh, rem_diff;
  logic [2*XLEN-1:0] prod, prod_fix;

  always_comb begin
    is_div = op_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    a_sgn  = op_i inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_sgn  = op_i inside {ALU_MULH, ALU_DIV, ALU_REM};
    neg_a  = a_sgn && a_i[XLEN-1];
    neg_b  = b_sgn && b_i[XLEN-1];
    a_abs  = neg_a ? -a_i : a_i;
    b_abs  = neg_b ? -b_i : b_i;
  end

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh   = {hi_q, lo_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
  end

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opb_d   = opb_q;
    div_d   = div_q;
    hsel_d  = hsel_q;
    neg_d   = neg_q;
    bzero_d = bzero_q;
    if (kill_i) begin
      run_d = 1'b0;
    end else if (start_i) begin
      run_d   = 1'b1;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = a_abs;
      opb_d   = b_abs;
      div_d   = is_div;
      hsel_d  = op_i inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
      // Remainder takes the dividend's sign; product/quotient the xor.
      neg_d   = (op_i inside {ALU_REM, ALU_REMU}) ? neg_a : (neg_a ^ neg_b);
      bzero_d = (b_i == '0);
    end else if (run_q) begin
      if (cnt_q == CW'(XLEN)) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (div_q) begin
          // Restoring step: borrow bit clear means shifted remainder >= divisor.
          if (!rem_diff[XLEN]) begin
            hi_d = rem_diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
      end
    end
  end

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    if (div_q) begin
      if (hsel_q)       res_o = neg_q ? -hi_q : hi_q;
      else if (bzero_q) res_o = '1;
      else              res_o = neg_q ? -lo_q : lo_q;
    end else begin
      res_o = hsel_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  assign done_o = run_q && (cnt_q == CW'(XLEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      hsel_q  <= 1'b0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      hsel_q  <= hsel_d;
      neg_q   <= neg_d;
      bzero_q <= bzero_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ex_stage_mc.sv
// ============================================================================
//  Module   : ex_stage_mc
//  Purpose  : Execute stage with operand forwarding, single-cycle ALU/branch
//             and iterative M-ops, registered valid/ready output.
//  Ports    : clk, rst_n   clock, async active-low reset
//             bus          ex_stage_mc_if.slave: request, result, flush, busy
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_stage_mc
  import ex_stage_mc_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int NFWD   = 3,
  parameter int MDU_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ex_stage_mc_if.slave bus
);

  localparam int SELW = $clog2(NFWD + 1);
  localparam int SHW  = $clog2(XLEN);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d, is_jump_q, is_jump_d;
  logic [XLEN-1:0] alures_q, alures_d, rs2_q, rs2_d, pc_next_q, pc_next_d;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd, src1, src2, alu_res, br_target, mdu_res;
  logic [SHW-1:0]  shamt;
  logic            br_cond, take_jump, accept, op_is_m, mdu_done;

  // Select FWD_RF or any out-of-range select falls through to the regfile.
  always_comb begin
    rs1_fwd = bus.rs1_i;
    rs2_fwd = bus.rs2_i;
    for (int k = 0; k < NFWD; k++) begin
      if (bus.rs1_sel_i == SELW'(k + 1)) rs1_fwd = bus.fwd_data_i[k*XLEN +: XLEN];
      if (bus.rs2_sel_i == SELW'(k + 1)) rs2_fwd = bus.fwd_data_i[k*XLEN +: XLEN];
    end
  end

  assign src1  = bus.src1sel_i ? bus.pc_i : rs1_fwd;
  assign src2  = bus.src2sel_i[1] ? XLEN'(4) : (bus.src2sel_i[0] ? bus.imm_i : rs2_fwd);
  assign shamt = src2[SHW-1:0];

  // M-ops fall into the default (ADD) arm; when the MDU exists its result
  // replaces this one anyway.
  always_comb begin
    case (bus.aluctr_i)
      ALU_SUB:  alu_res = src1 - src2;
      ALU_SLL:  alu_res = src1 << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src1 < src2};
      ALU_XOR:  alu_res = src1 ^ src2;
      ALU_SRL:  alu_res = src1 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src1) >>> shamt);
      ALU_OR:   alu_res = src1 | src2;
      ALU_AND:  alu_res = src1 & src2;
      ALU_LUI:  alu_res = src2;
      default:  alu_res = src1 + src2;
    endcase
  end

  always_comb begin
    case (bus.fun3_i)
      F3_BEQ:  br_cond = (rs1_fwd == rs2_fwd);
      F3_BNE:  br_cond = (rs1_fwd != rs2_fwd);
      F3_BLT:  br_cond = ($signed(rs1_fwd) <  $signed(rs2_fwd));
      F3_BGE:  br_cond = ($signed(rs1_fwd) >= $signed(rs2_fwd));
      F3_BLTU: br_cond = (rs1_fwd <  rs2_fwd);
      F3_BGEU: br_cond = (rs1_fwd >= rs2_fwd);
      default: br_cond = 1'b0;
    endcase
    br_target = bus.is_jalr_i ? ((rs1_fwd + bus.imm_i) & ~XLEN'(1)) : (bus.pc_i + bus.imm_i);
    take_jump = bus.is_jal_i | bus.is_jalr_i | (bus.is_brc_i & br_cond);
  end

  assign op_is_m        = (MDU_EN != 0) && is_mop(bus.aluctr_i);
  assign bus.in_ready_o = !bus.flush_i &&
                          ((state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready_i));
  assign accept         = bus.in_valid_i && bus.in_ready_o;

  if (MDU_EN != 0) begin : g_mdu
    ex_mdu #(.XLEN(XLEN)) u_mdu (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (accept && op_is_m),
      .kill_i  (bus.flush_i),
      .op_i    (bus.aluctr_i),
      .a_i     (rs1_fwd),
      .b_i     (rs2_fwd),
      .done_o  (mdu_done),
      .res_o   (mdu_res)
    );
  end else begin : g_no_mdu
    assign mdu_done = 1'b0;
    assign mdu_res  = '0;
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alures_d    = alures_q;
    rs2_d       = rs2_q;
    pc_next_d   = pc_next_q;
    is_jump_d   = is_jump_q;
    if (bus.flush_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      is_jump_d   = 1'b0;
    end else if (accept) begin
      // Covers both a fresh op from IDLE and a back-to-back op from HOLD.
      alures_d  = alu_res;
      rs2_d     = rs2_fwd;
      pc_next_d = br_target;
      is_jump_d = take_jump;
      if (op_is_m) begin
        state_d     = S_BUSY;
        out_valid_d = 1'b0;
      end else begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_BUSY: if (mdu_done) begin
          alures_d    = mdu_res;
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
        end
        S_HOLD: if (bus.out_ready_i) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      alures_q    <= '0;
      rs2_q       <= '0;
      pc_next_q   <= '0;
      is_jump_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alures_q    <= alures_d;
      rs2_q       <= rs2_d;
      pc_next_q   <= pc_next_d;
      is_jump_q   <= is_jump_d;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.alures_o    = alures_q;
  assign bus.rs2_o       = rs2_q;
  assign bus.pc_next_o   = pc_next_q;
  assign bus.is_jump_o   = is_jump_q;
  assign bus.busy_o      = (state_q == S_BUSY);

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_mc.sv
// ============================================================================
//  Module   : tb_ex_stage_mc
//  Purpose  : Directed self-checking bench for ex_stage_mc.
//  Ports    : none (top-level bench)
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_stage_mc;
  import ex_stage_mc_pkg::*;

  localparam int XLEN = 64;
  localparam int NFWD = 4;
  localparam int SELW = $clog2(NFWD + 1);

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_stage_mc_if #(.XLEN(XLEN), .NFWD(NFWD)) bus ();

  ex_stage_mc #(.XLEN(XLEN), .NFWD(NFWD), .MDU_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input alu_op_e op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    bus.in_valid_i = 1'b1;
    bus.aluctr_i   = op;
    bus.rs1_i      = a;
    bus.rs2_i      = b;
    bus.imm_i      = '0;
    bus.pc_i       = '0;
    bus.fun3_i     = 3'b000;
    bus.src1sel_i  = 1'b0;
    bus.src2sel_i  = 2'b00;
    bus.rs1_sel_i  = '0;
    bus.rs2_sel_i  = '0;
    bus.is_jal_i   = 1'b0;
    bus.is_jalr_i  = 1'b0;
    bus.is_brc_i   = 1'b0;
  endtask

  // Let the accept edge pass, then drop the request.
  task automatic step();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic settle();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.flush_i     = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_mop(input string tag, input alu_op_e op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp);
    drive(op, a, b);
    step();
    for (int i = 0; i < 200 && !bus.out_valid_o; i++) @(negedge clk);
    check_eq({tag, " valid"}, XLEN'(bus.out_valid_o), XLEN'(1));
    check_eq(tag, bus.alures_o, exp);
  endtask

  int bad;

  initial begin
    drive(ALU_ADD, '0, '0);
    bus.in_valid_i  = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b1;
    bus.fwd_data_i  = {64'h4444, 64'h3333, 64'h55, 64'h1111};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst out_valid", XLEN'(bus.out_valid_o), '0);
    check_eq("rst busy", XLEN'(bus.busy_o), '0);
    check_eq("rst is_jump", XLEN'(bus.is_jump_o), '0);
    check_eq("rst alures", bus.alures_o, '0);
    check_eq("rst rs2", bus.rs2_o, '0);
    check_eq("rst pc_next", bus.pc_next_o, '0);
    check_eq("rst in_ready", XLEN'(bus.in_ready_o), XLEN'(1));
    rst_n = 1'b1;
    @(negedge clk);

    // ADD with one-cycle latency
    drive(ALU_ADD, 64'd5, 64'd7);
    #1 check_eq("add pre valid", XLEN'(bus.out_valid_o), '0);
    step();
    check_eq("add valid", XLEN'(bus.out_valid_o), XLEN'(1));
    check_eq("add res", bus.alures_o, 64'd12);

    // Forwarding
    drive(ALU_ADD, 64'h100, 64'h1); bus.rs1_sel_i = SELW'(2);
    step();
    check_eq("fwd rs1 src1", bus.alures_o, 64'h56);
    drive(ALU_ADD, 64'h100, 64'h1); bus.rs1_sel_i = SELW'(2); bus.rs2_sel_i = SELW'(1);
    step();
    check_eq("fwd rs2 res", bus.alures_o, 64'h1166);
    check_eq("fwd rs2 store", bus.rs2_o, 64'h1111);
    drive(ALU_ADD, 64'h100, 64'h1); bus.rs1_sel_i = SELW'(NFWD + 1);
    step();
    check_eq("fwd sel>NFWD", bus.alures_o, 64'h101);
    drive(ALU_ADD, 64'h100, 64'h1); bus.rs1_sel_i = SELW'(7);
    step();
    check_eq("fwd sel=7", bus.alures_o, 64'h101);

    // Misc ALU
    drive(ALU_SRA, -64'sd16, '0); bus.src2sel_i = 2'b01; bus.imm_i = 64'd2;
    step();
    check_eq("sra", bus.alures_o, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(ALU_SLL, 64'd1, 64'd65);
    step();
    check_eq("sll mod", bus.alures_o, 64'd2);
    drive(ALU_SLT, ONES, 64'd1);
    step();
    check_eq("slt", bus.alures_o, 64'd1);
    drive(ALU_SUB, 64'd3, 64'd5);
    step();
    check_eq("sub", bus.alures_o, 64'hFFFF_FFFF_FFFF_FFFE);

    // DIV latency / busy / ready
    settle();
    drive(ALU_DIV, -64'sd7, 64'd2);
    step();
    bad = 0;
    for (int k = 0; k < XLEN + 1; k++) begin
      if (bus.busy_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b0) bad++;
      @(negedge clk);
    end
    check_eq("div busy window", XLEN'(bad), '0);
    check_eq("div valid at XLEN+1", XLEN'(bus.out_valid_o), XLEN'(1));
    check_eq("div busy cleared", XLEN'(bus.busy_o), '0);
    check_eq("div -7/2", bus.alures_o, 64'hFFFF_FFFF_FFFF_FFFD);

    // M-op corner values
    run_mop("divu x/0", ALU_DIVU, 64'd123, '0, ONES);
    run_mop("rem min/-1", ALU_REM, MIN, ONES, '0);
    run_mop("mulhu ones", ALU_MULHU, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE);
    run_mop("div min/-1", ALU_DIV, MIN, ONES, MIN);
    run_mop("mul 6*7", ALU_MUL, 64'd6, 64'd7, 64'd42);
    run_mop("mulh -2*3", ALU_MULH, -64'sd2, 64'd3, ONES);
    run_mop("mulhsu -1*2", ALU_MULHSU, ONES, 64'd2, ONES);
    run_mop("rem -7/2", ALU_REM, -64'sd7, 64'd2, ONES);
    run_mop("div -20/0", ALU_DIV, -64'sd20, '0, ONES);
    run_mop("rem -20/0", ALU_REM, -64'sd20, '0, -64'sd20);

    // HOLD stall then back-to-back accept
    settle();
    drive(ALU_ADD, 64'd10, 64'd20);
    bus.out_ready_i = 1'b0;
    step();
    check_eq("hold valid", XLEN'(bus.out_valid_o), XLEN'(1));
    check_eq("hold res", bus.alures_o, 64'd30);
    drive(ALU_SUB, 64'd100, 64'd1);
    #1 check_eq("hold in_ready", XLEN'(bus.in_ready_o), '0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b1 || bus.alures_o !== 64'd30 || bus.in_ready_o !== 1'b0) bad++;
    end
    check_eq("hold stable", XLEN'(bad), '0);
    bus.out_ready_i = 1'b1;
    #1 check_eq("b2b in_ready", XLEN'(bus.in_ready_o), XLEN'(1));
    step();
    check_eq("b2b valid", XLEN'(bus.out_valid_o), XLEN'(1));
    check_eq("b2b res", bus.alures_o, 64'd99);
    @(negedge clk);
    check_eq("drain valid", XLEN'(bus.out_valid_o), '0);

    // Flush during DIV
    settle();
    drive(ALU_DIV, 64'd100, 64'd3);
    step();
    repeat (9) @(negedge clk);
    check_eq("flush pre busy", XLEN'(bus.busy_o), XLEN'(1));
    drive(ALU_ADD, 64'd1, 64'd1);
    bus.flush_i = 1'b1;
    #1 check_eq("flush in_ready", XLEN'(bus.in_ready_o), '0);
    @(negedge clk);
    check_eq("flush valid", XLEN'(bus.out_valid_o), '0);
    check_eq("flush busy", XLEN'(bus.busy_o), '0);
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    #1 check_eq("flush idle ready", XLEN'(bus.in_ready_o), XLEN'(1));
    repeat (80) @(negedge clk);
    check_eq("flush no stale", XLEN'(bus.out_valid_o), '0);
    run_mop("mul after flush", ALU_MUL, 64'd3, 64'd4, 64'd12);

    // Branches and jumps
    drive(ALU_ADD, 64'd9, 64'd9); bus.pc_i = 64'h1000; bus.imm_i = 64'h20;
    bus.fun3_i = F3_BEQ; bus.is_brc_i = 1'b1;
    step();
    check_eq("beq jump", XLEN'(bus.is_jump_o), XLEN'(1));
    check_eq("beq target", bus.pc_next_o, 64'h1020);
    drive(ALU_ADD, 64'd9, 64'd9); bus.fun3_i = F3_BNE; bus.is_brc_i = 1'b1;
    step();
    check_eq("bne jump", XLEN'(bus.is_jump_o), '0);
    drive(ALU_ADD, ONES, 64'd1); bus.fun3_i = F3_BLT; bus.is_brc_i = 1'b1;
    step();
    check_eq("blt jump", XLEN'(bus.is_jump_o), XLEN'(1));
    drive(ALU_ADD, ONES, 64'd1); bus.fun3_i = F3_BLTU; bus.is_brc_i = 1'b1;
    step();
    check_eq("bltu jump", XLEN'(bus.is_jump_o), '0);
    drive(ALU_ADD, ONES, 64'd1); bus.fun3_i = F3_BGEU; bus.is_brc_i = 1'b1;
    step();
    check_eq("bgeu jump", XLEN'(bus.is_jump_o), XLEN'(1));
    drive(ALU_ADD, 64'h2001, '0); bus.imm_i = 64'd4; bus.is_jalr_i = 1'b1;
    bus.pc_i = 64'h500; bus.src1sel_i = 1'b1; bus.src2sel_i = 2'b10;
    step();
    check_eq("jalr target", bus.pc_next_o, 64'h2004);
    check_eq("jalr jump", XLEN'(bus.is_jump_o), XLEN'(1));
    check_eq("jalr link", bus.alures_o, 64'h504);
    drive(ALU_ADD, '0, '0); bus.pc_i = 64'h3000; bus.imm_i = 64'h100; bus.is_jal_i = 1'b1;
    bus.src1sel_i = 1'b1; bus.src2sel_i = 2'b10;
    step();
    check_eq("jal link", bus.alures_o, 64'h3004);
    check_eq("jal target", bus.pc_next_o, 64'h3100);

    // Async reset mid-iteration
    settle();
    drive(ALU_MUL, 64'd5, 64'd5);
    step();
    repeat (5) @(negedge clk);
    check_eq("arst pre busy", XLEN'(bus.busy_o), XLEN'(1));
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst busy", XLEN'(bus.busy_o), '0);
    check_eq("arst alures", bus.alures_o, '0);
    check_eq("arst pc_next", bus.pc_next_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("arst idle ready", XLEN'(bus.in_ready_o), XLEN'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
